// File: rtl/tl_timer_ctrl_pkg.sv
// Shared definitions for the traffic-light timer/request conditioner:
// timer state encoding, config selects and default durations.
package tl_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_S = 2'd1,
    RUN_L = 2'd2,
    DONE  = 2'd3
  } tmr_state_e;

  localparam logic CFG_SHORT = 1'b0;
  localparam logic CFG_LONG  = 1'b1;

  localparam int TW_DEF_C    = 8;
  localparam int SHORT_DEF_C = 5;
  localparam int LONG_DEF_C  = 20;
  localparam int DEB_DEF_C   = 3;

endpackage

// File: rtl/tl_timer_ctrl_if.sv
// Signal bundle between the traffic-light fsm / sensors / config bus and the timer block.
interface tl_timer_ctrl_if
  import tl_timer_ctrl_pkg::*;
#(
  parameter int TW = TW_DEF_C
);
  logic          ST;
  logic          C_raw;
  logic          PB;
  logic          MG;
  logic          cfg_we;
  logic          cfg_sel;
  logic [TW-1:0] cfg_data;
  logic          TS;
  logic          TL;
  logic          C;
  logic          ped_pending;
  logic [TW-1:0] timer_val;

  // fsm / environment side
  modport master (
    output ST, C_raw, PB, MG, cfg_we, cfg_sel, cfg_data,
    input  TS, TL, C, ped_pending, timer_val
  );

  // timer block side
  modport slave (
    input  ST, C_raw, PB, MG, cfg_we, cfg_sel, cfg_data,
    output TS, TL, C, ped_pending, timer_val
  );
endinterface

// File: rtl/tl_timer_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the synchronized input after DEB consecutive differing samples.
module tl_timer_ctrl_debounce #(
  parameter int DEB = 3
) (
  input  logic Clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

  logic [1:0]    sync_r;
  logic          deb_r;
  logic [CW-1:0] cnt_r;

  // synchronize the raw input and count consecutive samples that disagree with the filtered value
  always_ff @(posedge Clk) begin
    if (!reset) begin
      sync_r <= 2'b00;
      deb_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      sync_r <= {sync_r[0], din};
      if (sync_r[1] != deb_r) begin
        if (cnt_r == CW'(DEB - 1)) begin
          deb_r <= sync_r[1];
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign dout = deb_r;
endmodule

// File: rtl/tl_timer_ctrl.sv
// Interval timer (short/long expiry levels for the fsm) plus side-street request
// conditioning: debounced car sensor OR latched pedestrian request.
module tl_timer_ctrl
  import tl_timer_ctrl_pkg::*;
#(
  parameter int TW        = TW_DEF_C,
  parameter int SHORT_DEF = SHORT_DEF_C,
  parameter int LONG_DEF  = LONG_DEF_C,
  parameter int DEB       = DEB_DEF_C
) (
  input  logic          Clk,
  input  logic          reset,
  tl_timer_ctrl_if.slave bus
);
  localparam logic [TW-1:0] CNT_MAX_C   = {TW{1'b1}};
  localparam logic [TW-1:0] SHORT_RST_C = TW'(SHORT_DEF);
  localparam logic [TW-1:0] LONG_RST_C  = TW'(LONG_DEF);
  localparam logic [TW-1:0] ONE_C       = TW'(1);

  tmr_state_e    state_r, state_s;
  logic [TW-1:0] cfg_s_r, cfg_l_r, shadow_s_r, shadow_l_r;
  logic [TW-1:0] cnt_r, cnt_s, cnt_inc_s, s_eff_s, l_eff_s;
  logic          ts_r, tl_r, ts_s, tl_s;
  logic [1:0]    pb_sync_r;
  logic          pb_prev_r, mg_r, ped_r, c_r;
  logic          c_deb_s, pb_rise_s, mg_fall_s;

  // config registers; a write only takes effect at the next timer start
  always_ff @(posedge Clk) begin
    if (!reset) begin
      cfg_s_r <= SHORT_RST_C;
      cfg_l_r <= LONG_RST_C;
    end else if (bus.cfg_we) begin
      if (bus.cfg_sel == CFG_LONG) begin
        cfg_l_r <= bus.cfg_data;
      end else begin
        cfg_s_r <= bus.cfg_data;
      end
    end
  end

  // timer state register, counter, shadowed durations and registered expiry levels
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      shadow_s_r <= SHORT_RST_C;
      shadow_l_r <= LONG_RST_C;
      ts_r       <= 1'b0;
      tl_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ts_r    <= ts_s;
      tl_r    <= tl_s;
      if (bus.ST) begin
        shadow_s_r <= cfg_s_r;
        shadow_l_r <= cfg_l_r;
      end
    end
  end

  // effective durations: short at least 1, long never shorter than short
  always_comb begin
    s_eff_s = shadow_s_r;
    l_eff_s = shadow_l_r;
    if (shadow_s_r == '0) begin
      s_eff_s = ONE_C;
    end else begin
      s_eff_s = shadow_s_r;
    end
    if (shadow_l_r < s_eff_s) begin
      l_eff_s = s_eff_s;
    end else begin
      l_eff_s = shadow_l_r;
    end
  end

  assign cnt_inc_s = (cnt_r == CNT_MAX_C) ? cnt_r : (cnt_r + ONE_C);

  // next-state and counter; a start pulse overrides every state
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (bus.ST) begin
      state_s = RUN_S;
      cnt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
        RUN_S: begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s >= l_eff_s) begin
            state_s = DONE;
          end else if (cnt_inc_s >= s_eff_s) begin
            state_s = RUN_L;
          end else begin
            state_s = RUN_S;
          end
        end
        RUN_L: begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s >= l_eff_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN_L;
          end
        end
        DONE: begin
          state_s = DONE;
          cnt_s   = cnt_r;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // expiry levels decoded from the upcoming state so TS/TL land on the expiry edge
  always_comb begin
    ts_s = 1'b0;
    tl_s = 1'b0;
    case (state_s)
      RUN_L: begin
        ts_s = 1'b1;
        tl_s = 1'b0;
      end
      DONE: begin
        ts_s = 1'b1;
        tl_s = 1'b1;
      end
      default: begin
        ts_s = 1'b0;
        tl_s = 1'b0;
      end
    endcase
  end

  tl_timer_ctrl_debounce #(.DEB(DEB)) u_car_deb (
    .Clk   (Clk),
    .reset (reset),
    .din   (bus.C_raw),
    .dout  (c_deb_s)
  );

  assign pb_rise_s = pb_sync_r[1] & ~pb_prev_r;
  assign mg_fall_s = mg_r & ~bus.MG;

  // pedestrian synchronizer, MG edge tracking, request latch and combined request
  always_ff @(posedge Clk) begin
    if (!reset) begin
      pb_sync_r <= 2'b00;
      pb_prev_r <= 1'b0;
      mg_r      <= 1'b0;
      ped_r     <= 1'b0;
      c_r       <= 1'b0;
    end else begin
      pb_sync_r <= {pb_sync_r[0], bus.PB};
      pb_prev_r <= pb_sync_r[1];
      mg_r      <= bus.MG;
      if (pb_rise_s) begin
        ped_r <= 1'b1;
      end else if (mg_fall_s) begin
        ped_r <= 1'b0;
      end
      c_r <= c_deb_s | ped_r;
    end
  end

  assign bus.TS          = ts_r;
  assign bus.TL          = tl_r;
  assign bus.C           = c_r;
  assign bus.ped_pending = ped_r;
  assign bus.timer_val   = cnt_r;
endmodule

// File: tb/tb_tl_timer_ctrl.sv
// Self-checking bench for tl_timer_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the rules.
module tb_tl_timer_ctrl;
  localparam int TW_C  = 8;
  localparam int DEB_C = 3;
  localparam int SD_C  = 5;
  localparam int LD_C  = 20;

  logic Clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tl_timer_ctrl_if #(.TW(TW_C)) bus ();

  tl_timer_ctrl #(.TW(TW_C), .SHORT_DEF(SD_C), .LONG_DEF(LD_C), .DEB(DEB_C)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference model state
  int n = 0;
  int k = 0;
  bit running = 0;
  int s_m = SD_C;
  int l_m = LD_C;
  int cfg_s_m = SD_C;
  int cfg_l_m = LD_C;
  bit r_h [0:DEB_C+1];
  bit p_h [0:3];
  bit deb_m = 0;
  bit ped_m = 0;
  bit c_m = 0;
  bit m_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit same;
    n = n + 1;
    if (!reset) begin
      running = 0;
      cfg_s_m = SD_C;
      cfg_l_m = LD_C;
      for (int i = 0; i <= DEB_C + 1; i++) r_h[i] = 0;
      for (int i = 0; i < 4; i++) p_h[i] = 0;
      deb_m = 0; ped_m = 0; c_m = 0; m_prev = 0;
    end else begin
      c_m = deb_m | ped_m;
      if (bus.ST) begin
        running = 1;
        k = n;
        s_m = (cfg_s_m == 0) ? 1 : cfg_s_m;
        l_m = (cfg_l_m < s_m) ? s_m : cfg_l_m;
      end
      if (bus.cfg_we) begin
        if (bus.cfg_sel) cfg_l_m = int'(bus.cfg_data);
        else cfg_s_m = int'(bus.cfg_data);
      end
      for (int i = DEB_C + 1; i > 0; i--) r_h[i] = r_h[i-1];
      r_h[0] = bus.C_raw;
      for (int i = 3; i > 0; i--) p_h[i] = p_h[i-1];
      p_h[0] = bus.PB;
      same = 1;
      for (int i = 3; i <= DEB_C + 1; i++) if (r_h[i] != r_h[2]) same = 0;
      if (same && (r_h[2] != deb_m)) deb_m = r_h[2];
      if (p_h[2] && !p_h[3]) ped_m = 1;
      else if (m_prev && !bus.MG) ped_m = 0;
      m_prev = bus.MG;
    end
  endtask

  task automatic tick();
    int el;
    int tv;
    @(posedge Clk);
    model_edge();
    #1;
    el = n - k;
    tv = running ? ((el < l_m) ? el : l_m) : 0;
    chk("TS", 32'(bus.TS), 32'(running && (el >= s_m)));
    chk("TL", 32'(bus.TL), 32'(running && (el >= l_m)));
    chk("timer_val", 32'(bus.timer_val), 32'(tv));
    chk("C", 32'(bus.C), 32'(c_m));
    chk("ped_pending", 32'(bus.ped_pending), 32'(ped_m));
  endtask

  task automatic cfg_write(input logic sel, input int val);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_data = TW_C'(val);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.ST = 1'b0; bus.C_raw = 1'b0; bus.PB = 1'b0; bus.MG = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_data = '0;

    // reset for two edges
    tick(); tick();
    chk("rst_TS", 32'(bus.TS), 32'd0);
    chk("rst_C", 32'(bus.C), 32'd0);
    chk("rst_tv", 32'(bus.timer_val), 32'd0);
    reset = 1'b1;
    tick();

    // default durations; short rewritten mid-run does not affect this interval
    bus.ST = 1'b1; tick(); bus.ST = 1'b0;
    cfg_write(1'b0, 3);
    repeat (3) tick();
    chk("def_TS_k4", 32'(bus.TS), 32'd0);
    tick();
    chk("def_TS_k5", 32'(bus.TS), 32'd1);
    chk("def_TL_k5", 32'(bus.TL), 32'd0);
    repeat (14) tick();
    chk("def_TL_k19", 32'(bus.TL), 32'd0);
    tick();
    chk("def_TL_k20", 32'(bus.TL), 32'd1);
    repeat (3) tick();
    chk("done_hold_tv", 32'(bus.timer_val), 32'd20);
    chk("done_hold_TS", 32'(bus.TS), 32'd1);

    // new short duration picked up by the next start
    bus.ST = 1'b1; tick(); bus.ST = 1'b0;
    repeat (2) tick();
    chk("new_TS_k2", 32'(bus.TS), 32'd0);
    tick();
    chk("new_TS_k3", 32'(bus.TS), 32'd1);

    // long shorter than short: both rise together
    cfg_write(1'b0, 10);
    cfg_write(1'b1, 4);
    bus.ST = 1'b1; tick(); bus.ST = 1'b0;
    repeat (9) tick();
    chk("eq_TS_k9", 32'(bus.TS), 32'd0);
    tick();
    chk("eq_TS_k10", 32'(bus.TS), 32'd1);
    chk("eq_TL_k10", 32'(bus.TL), 32'd1);

    // bouncing car sensor
    bus.C_raw = 1'b1; tick();
    bus.C_raw = 1'b0; tick();
    bus.C_raw = 1'b1;
    repeat (5) tick();
    chk("deb_C_early", 32'(bus.C), 32'd0);
    tick();
    chk("deb_C_set", 32'(bus.C), 32'd1);
    bus.C_raw = 1'b0;
    repeat (8) tick();

    // pedestrian latch, clear on MG fall, set wins over clear
    bus.MG = 1'b1; repeat (2) tick();
    bus.PB = 1'b1; tick(); bus.PB = 1'b0;
    repeat (3) tick();
    chk("ped_set", 32'(bus.ped_pending), 32'd1);
    chk("ped_C", 32'(bus.C), 32'd1);
    bus.MG = 1'b0; tick();
    chk("ped_clr", 32'(bus.ped_pending), 32'd0);
    bus.MG = 1'b1; bus.PB = 1'b1; tick();
    bus.PB = 1'b0; tick();
    bus.MG = 1'b0; tick();
    chk("ped_set_wins", 32'(bus.ped_pending), 32'd1);
    bus.MG = 1'b1; bus.PB = 1'b0; tick(); bus.MG = 1'b0; repeat (2) tick();

    // restart while in RUN_L
    cfg_write(1'b0, 5);
    cfg_write(1'b1, 20);
    bus.ST = 1'b1; tick(); bus.ST = 1'b0;
    repeat (7) tick();
    chk("runl_TS", 32'(bus.TS), 32'd1);
    bus.ST = 1'b1; tick(); bus.ST = 1'b0;
    chk("restart_TS", 32'(bus.TS), 32'd0);
    chk("restart_tv", 32'(bus.timer_val), 32'd0);
    tick();
    chk("restart_tv1", 32'(bus.timer_val), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.ST     = ($urandom_range(0, 15) == 0);
      bus.cfg_we = ($urandom_range(0, 7) == 0);
      bus.cfg_sel = $urandom_range(0, 1) == 1;
      bus.cfg_data = TW_C'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) bus.C_raw = ~bus.C_raw;
      if ($urandom_range(0, 5) == 0) bus.PB = ~bus.PB;
      if ($urandom_range(0, 9) == 0) bus.MG = ~bus.MG;
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
